// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: forwarding selects (same values as the
// datapath ID_*_FWD_* constants), interrupt FSM states and the forwarding priority function.
package pipe_ctrl_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_EXE_ALU  = 2'd0,
        FWD_MEM_ALU  = 2'd1,
        FWD_MEM_LOAD = 2'd2,
        FWD_REGFILE  = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TAKE = 2'd1,
        ST_ISR  = 2'd2
    } irq_state_e;

    // EXE beats MEM; a load in EXE has no data yet, so it falls through to MEM/regfile
    // and the load-use stall covers it.
    function automatic fwd_sel_e fwd_select(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] exe_addr,
        input logic              exe_wen,
        input logic              exe_load,
        input logic [REG_AW-1:0] mem_addr,
        input logic              mem_wen,
        input logic              mem_ren
    );
        fwd_sel_e sel;
        sel = FWD_REGFILE;
        if (src == '0)
            sel = FWD_REGFILE;
        else if (exe_wen && !exe_load && (exe_addr == src))
            sel = FWD_EXE_ALU;
        else if (mem_wen && !mem_ren && (mem_addr == src))
            sel = FWD_MEM_ALU;
        else if (mem_wen && mem_ren && (mem_addr == src))
            sel = FWD_MEM_LOAD;
        return sel;
    endfunction

endpackage

// File: rtl/pipe_ctrl_irq_sync.sv
// irq_sync: N-flop synchroniser for an asynchronous level input.
// Latency STAGES cycles; no backpressure.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sync <= '0;
        else
            r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage MIPS stage controls, ID forwarding, load-use stall, IRQ/ERET redirect.
// Forwarding/stall combinational; jump_en/jump_addr registered (1 cycle); a stall freezes IF/ID.
// PIPE_CTRL_IRQ_EN compiles in the irq synchroniser, interrupt FSM, EPC and ERET handling.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC_ADDR    = 32'h0000_0010,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] addr_rs,
    input  logic [REG_AW-1:0] addr_rt,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              is_store_id,
    input  logic              is_branch_id,
    input  logic              eret_id,
    input  logic [REG_AW-1:0] regw_addr_exe,
    input  logic              wb_wen_exe,
    input  logic              is_load_exe,
    input  logic [REG_AW-1:0] regw_addr_mem,
    input  logic              wb_wen_mem,
    input  logic              mem_ren_mem,
    input  logic [31:0]       inst_addr,
    input  logic [31:0]       inst_addr_id,
    input  logic              irq,
    output logic              if_rst,
    output logic              if_en,
    output logic              id_rst,
    output logic              id_en,
    output logic              exe_rst,
    output logic              exe_en,
    output logic              mem_rst,
    output logic              mem_en,
    output logic              wb_rst,
    output logic              wb_en,
    output logic [1:0]        fwd_a_ctrl,
    output logic [1:0]        fwd_b_ctrl,
    output logic              fwd_m,
    output logic              jump_en,
    output logic [31:0]       jump_addr,
    output logic              ie
);

    // Low through reset and the first edge after release, so every stage sees one reset edge.
    logic r_live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_live <= 1'b0;
        else
            r_live <= 1'b1;
    end

    logic w_load_hz;
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_store_byp;
    logic w_stall;
    logic w_take_flush;

    assign w_load_hz   = r_live && is_load_exe && (regw_addr_exe != '0);
    assign w_rs_hit    = rs_used && (addr_rs == regw_addr_exe);
    assign w_rt_hit    = rt_used && (addr_rt == regw_addr_exe);
    // A store only needing the loaded value as its data picks it up from WB next cycle.
    assign w_store_byp = w_load_hz && is_store_id && w_rt_hit && !w_rs_hit;
    assign w_stall     = w_load_hz && (w_rs_hit || w_rt_hit) && !w_store_byp;

    assign fwd_a_ctrl = r_live ? fwd_select(addr_rs, regw_addr_exe, wb_wen_exe, is_load_exe,
                                            regw_addr_mem, wb_wen_mem, mem_ren_mem)
                               : FWD_REGFILE;
    assign fwd_b_ctrl = r_live ? fwd_select(addr_rt, regw_addr_exe, wb_wen_exe, is_load_exe,
                                            regw_addr_mem, wb_wen_mem, mem_ren_mem)
                               : FWD_REGFILE;
    assign fwd_m      = !w_store_byp;

    assign if_rst  = !r_live;
    assign if_en   = r_live && !w_stall;
    assign id_en   = r_live && !w_stall;
    assign id_rst  = !r_live || jump_en;
    assign exe_rst = !r_live || w_stall || w_take_flush;
    assign exe_en  = r_live;
    assign mem_rst = !r_live;
    assign mem_en  = r_live;
    assign wb_rst  = !r_live;
    assign wb_en   = r_live;

`ifdef PIPE_CTRL_IRQ_EN
    logic       w_irq_s;
    irq_state_e r_state;
    irq_state_e w_state_nxt;
    logic       r_pend;
    logic       w_pend_nxt;
    logic       r_ie;
    logic       w_ie_nxt;
    logic [31:0] r_epc;
    logic [31:0] w_epc_nxt;
    logic       r_jump_en;
    logic       w_jump_en_nxt;
    logic [31:0] r_jump_addr;
    logic [31:0] w_jump_addr_nxt;
    logic       w_eret_ok;
    logic       w_req;

    irq_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (irq),
        .o_q   (w_irq_s)
    );

    assign w_eret_ok = r_live && eret_id && !w_stall && (r_state != ST_TAKE);
    assign w_req     = r_pend || w_irq_s;

    always_comb begin
        w_state_nxt     = r_state;
        w_pend_nxt      = r_pend;
        w_ie_nxt        = r_ie;
        w_epc_nxt       = r_epc;
        w_jump_en_nxt   = 1'b0;
        w_jump_addr_nxt = r_jump_addr;
        case (r_state)
            ST_RUN: begin
                // Request is latched so a stall or a competing ERET only defers it.
                w_pend_nxt = r_pend || (w_irq_s && r_ie);
                if (w_eret_ok) begin
                    w_jump_en_nxt   = 1'b1;
                    w_jump_addr_nxt = r_epc;
                    w_ie_nxt        = 1'b1;
                end else if (r_live && w_req && r_ie && !w_stall) begin
                    w_state_nxt     = ST_TAKE;
                    w_pend_nxt      = 1'b0;
                    w_jump_en_nxt   = 1'b1;
                    w_jump_addr_nxt = VEC_ADDR;
                end
            end
            ST_TAKE: begin
                w_epc_nxt   = is_branch_id ? inst_addr_id : inst_addr;
                w_ie_nxt    = 1'b0;
                w_pend_nxt  = 1'b0;
                w_state_nxt = ST_ISR;
            end
            ST_ISR: begin
                if (w_eret_ok) begin
                    w_jump_en_nxt   = 1'b1;
                    w_jump_addr_nxt = r_epc;
                    w_ie_nxt        = 1'b1;
                    w_state_nxt     = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_pend      <= 1'b0;
            r_ie        <= 1'b1;
            r_epc       <= '0;
            r_jump_en   <= 1'b0;
            r_jump_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_ie        <= w_ie_nxt;
            r_epc       <= w_epc_nxt;
            r_jump_en   <= w_jump_en_nxt;
            r_jump_addr <= w_jump_addr_nxt;
        end
    end

    // A branch in ID is squashed with its delay slot so both re-execute from EPC.
    assign w_take_flush = (r_state == ST_TAKE) && is_branch_id;
    assign jump_en      = r_jump_en;
    assign jump_addr    = r_jump_addr;
    assign ie           = r_ie;
`else
    logic w_unused_irq;

    assign w_unused_irq = ^{irq, eret_id, is_branch_id, inst_addr, inst_addr_id};
    assign w_take_flush = 1'b0;
    assign jump_en      = 1'b0;
    assign jump_addr    = '0;
    assign ie           = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: forwarding/stall vector table plus IRQ/ERET sequences
// whose redirect targets are queued at stimulus time and popped when jump_en appears.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  addr_rs, addr_rt, regw_addr_exe, regw_addr_mem;
    logic        rs_used, rt_used, is_store_id, is_branch_id, eret_id;
    logic        wb_wen_exe, is_load_exe, wb_wen_mem, mem_ren_mem, irq;
    logic [31:0] inst_addr, inst_addr_id;
    logic        if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en;
    logic [1:0]  fwd_a_ctrl, fwd_b_ctrl;
    logic        fwd_m, jump_en, ie;
    logic [31:0] jump_addr;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.VEC_ADDR(32'h0000_0010), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .addr_rs(addr_rs), .addr_rt(addr_rt), .rs_used(rs_used), .rt_used(rt_used),
        .is_store_id(is_store_id), .is_branch_id(is_branch_id), .eret_id(eret_id),
        .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe), .is_load_exe(is_load_exe),
        .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem), .mem_ren_mem(mem_ren_mem),
        .inst_addr(inst_addr), .inst_addr_id(inst_addr_id), .irq(irq),
        .if_rst(if_rst), .if_en(if_en), .id_rst(id_rst), .id_en(id_en),
        .exe_rst(exe_rst), .exe_en(exe_en), .mem_rst(mem_rst), .mem_en(mem_en),
        .wb_rst(wb_rst), .wb_en(wb_en),
        .fwd_a_ctrl(fwd_a_ctrl), .fwd_b_ctrl(fwd_b_ctrl), .fwd_m(fwd_m),
        .jump_en(jump_en), .jump_addr(jump_addr), .ie(ie)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every jump_en cycle must match the oldest queued redirect target.
    always @(negedge clk) begin
        if (rst_n && jump_en) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL jump_unexpected: jump_en=1 addr=0x%0h, required jump_en=0", jump_addr);
            end else begin
                chk("jump_addr", jump_addr, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        addr_rs = 5'd1; addr_rt = 5'd2; rs_used = 1'b1; rt_used = 1'b1;
        is_store_id = 1'b0; is_branch_id = 1'b0; eret_id = 1'b0;
        regw_addr_exe = 5'd0; wb_wen_exe = 1'b0; is_load_exe = 1'b0;
        regw_addr_mem = 5'd0; wb_wen_mem = 1'b0; mem_ren_mem = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int lim);
        int k = 0;
        while (exp_q.size() != 0 && k < lim) begin
            cyc();
            k++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: %0d redirects still pending after %0d cycles, required 0",
                     name, exp_q.size(), lim);
            exp_q.delete();
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rsts"}, {if_rst, id_rst, exe_rst, mem_rst, wb_rst}, 5'b11111);
        chk({tag, "_ens"},  {if_en, id_en, exe_en, mem_en, wb_en}, 5'b00000);
        chk({tag, "_fwd"},  {fwd_a_ctrl, fwd_b_ctrl, fwd_m}, 5'b11111);
        chk({tag, "_jump"}, {jump_en, jump_addr}, 33'd0);
        chk({tag, "_ie"},   ie, IRQ_ON);
    endtask

    typedef struct {
        logic [4:0] rs, rt;
        logic       rsu, rtu, st;
        logic [4:0] ea;
        logic       ew, el;
        logic [4:0] ma;
        logic       mw, mr;
        logic [1:0] fa, fb;
        logic       fm, stall;
    } vec_t;

    localparam int NV = 14;
    vec_t vt[NV];

    initial begin
        // rs rt rsu rtu st | exe a,wen,load | mem a,wen,ren | fwd_a fwd_b fwd_m stall
        vt[0]  = '{5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b1, 1'b0};
        vt[1]  = '{5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0};
        vt[2]  = '{5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 2'd1, 2'd1, 1'b1, 1'b0};
        vt[3]  = '{5'd4, 5'd1, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b1, 1'b1};
        vt[4]  = '{5'd4, 5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 2'd2, 2'd3, 1'b1, 1'b0};
        vt[5]  = '{5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b0, 1'b0};
        vt[6]  = '{5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b1, 1'b1};
        vt[7]  = '{5'd4, 5'd2, 1'b0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b1, 1'b0};
        vt[8]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 2'd3, 2'd3, 1'b1, 1'b0};
        vt[9]  = '{5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0};
        vt[10] = '{5'd7, 5'd3, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 2'd1, 2'd3, 1'b1, 1'b1};
        vt[11] = '{5'd1, 5'd4, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b1, 1'b1};
        vt[12] = '{5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 2'd3, 2'd3, 1'b1, 1'b0};
        vt[13] = '{5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0};

        idle();
        irq = 1'b0;
        inst_addr = 32'h0;
        inst_addr_id = 32'h0;

        // Reset values, then the one-edge reset stretch.
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("if_rst_stretch", if_rst, 1'b1);
        chk("if_en_stretch", if_en, 1'b0);
        cyc();
        @(negedge clk);
        chk("if_rst_live", if_rst, 1'b0);
        chk("fixed_live", {exe_en, mem_en, wb_en, mem_rst, wb_rst}, 5'b11100);
        chk("fwd_a_idle", fwd_a_ctrl, 2'd3);
        cyc();

        for (int i = 0; i < NV; i++) begin
            addr_rs = vt[i].rs; addr_rt = vt[i].rt;
            rs_used = vt[i].rsu; rt_used = vt[i].rtu; is_store_id = vt[i].st;
            regw_addr_exe = vt[i].ea; wb_wen_exe = vt[i].ew; is_load_exe = vt[i].el;
            regw_addr_mem = vt[i].ma; wb_wen_mem = vt[i].mw; mem_ren_mem = vt[i].mr;
            @(negedge clk);
            chk($sformatf("v%0d_fwd_a", i), fwd_a_ctrl, vt[i].fa);
            chk($sformatf("v%0d_fwd_b", i), fwd_b_ctrl, vt[i].fb);
            chk($sformatf("v%0d_fwd_m", i), fwd_m, vt[i].fm);
            chk($sformatf("v%0d_if_en", i), if_en, !vt[i].stall);
            chk($sformatf("v%0d_id_en", i), id_en, !vt[i].stall);
            chk($sformatf("v%0d_exe_rst", i), exe_rst, vt[i].stall);
            cyc();
        end

        // irq pulse, non-branch in ID at 0x40: vector, then ERET back to 0x40.
        idle();
        inst_addr = 32'h40;
        inst_addr_id = 32'h3C;
        irq = 1'b1;
        if (IRQ_ON) exp_q.push_back(32'h10);
        cyc();
        irq = 1'b0;
        wait_drain("irq_take", 10);
        @(negedge clk);
        chk("ie_in_isr", ie, 1'b0);
        cyc();
        eret_id = 1'b1;
        if (IRQ_ON) exp_q.push_back(32'h40);
        cyc();
        eret_id = 1'b0;
        wait_drain("eret_to_epc", 5);
        @(negedge clk);
        chk("ie_after_eret", ie, IRQ_ON);
        cyc();

        // irq during a load-use stall with a branch in ID at 0x3C: deferred, not dropped.
        addr_rs = 5'd4; regw_addr_exe = 5'd4; wb_wen_exe = 1'b1; is_load_exe = 1'b1;
        is_branch_id = 1'b1; inst_addr_id = 32'h3C; inst_addr = 32'h44;
        irq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_if_en", i), if_en, 1'b0);
            cyc();
        end
        is_load_exe = 1'b0;
        if (IRQ_ON) exp_q.push_back(32'h10);
        @(negedge clk);
        chk("unstall_if_en", if_en, 1'b1);
        cyc();
        @(negedge clk);
        chk("take_exe_rst", exe_rst, IRQ_ON);
        chk("take_id_rst", id_rst, IRQ_ON);
        cyc();
        is_branch_id = 1'b0;
        inst_addr = 32'h80;
        wait_drain("stall_irq_take", 3);

        // ERET with irq still high: ERET first, then irq re-taken once ie is back.
        eret_id = 1'b1;
        if (IRQ_ON) begin
            exp_q.push_back(32'h3C);
            exp_q.push_back(32'h10);
        end
        cyc();
        eret_id = 1'b0;
        wait_drain("eret_then_irq", 8);
        irq = 1'b0;
        @(negedge clk);
        chk("ie_retaken", ie, 1'b0);
        cyc();
        eret_id = 1'b1;
        if (IRQ_ON) exp_q.push_back(32'h80);
        cyc();
        eret_id = 1'b0;
        wait_drain("eret_to_80", 5);

        // Reset mid-operation discards a request still in the synchroniser.
        irq = 1'b1;
        cyc();
        irq = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("midreset");
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (8) cyc();
        @(negedge clk);
        chk("post_reset_ie", ie, IRQ_ON);
        chk("post_reset_q", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, required completion");
        $fatal(1);
    end

endmodule
